// File: rtl/slot_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : slot_mux_pkg
// Brief  : Shared constants, slot type and select decode for slot_mux.
// Rev    : 1.0  initial release
// ============================================================================
package slot_mux_pkg;

  // Number of time-multiplexed source ports and width of a port index.
  localparam int NUM_PORTS = 3;
  localparam int PORT_W    = 2;

  // Cycler select encodings; the cycler walks 10 -> 01 -> 00 -> 10.
  localparam logic [1:0] SEL_P0   = 2'b10;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b00;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Decoded slot: valid plus the port index that owns this cycle.
  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
  } slot_t;

  // Case-equality decode: an unknown or idle select yields no slot, so a
  // floating select line can never pop a FIFO.
  function automatic slot_t decode_sel(input logic [1:0] sel);
    slot_t s;
    s.valid = 1'b0;
    s.port  = '0;
    if (sel === SEL_P0) begin
      s.valid = 1'b1;
      s.port  = PORT_W'(0);
    end else if (sel === SEL_P1) begin
      s.valid = 1'b1;
      s.port  = PORT_W'(1);
    end else if (sel === SEL_P2) begin
      s.valid = 1'b1;
      s.port  = PORT_W'(2);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_fifo.sv
`default_nettype none
// ============================================================================
// Module : slot_fifo
// Brief  : Synchronous per-port FIFO with extra-MSB pointers, full/empty
//          flags and a combinational head word.
// Rev    : 1.0  initial release
// ============================================================================
module slot_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal means empty, wrap bits
  // differing with equal index bits means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Guards make push-on-full and pop-on-empty harmless no-ops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/slot_mux.sv
`default_nettype none
// ============================================================================
// Module : slot_mux
// Brief  : Time-division mux of three buffered ports onto one registered
//          valid/ready output, with the slot chosen by a 2-bit cycler select.
// Rev    : 1.0  initial release
// ============================================================================
import slot_mux_pkg::*;

module slot_mux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 sel,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]          out_port,
  input  logic                       out_ready
);

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [WIDTH-1:0]     head [NUM_PORTS];
  slot_t                slot;
  logic                 out_free;
  logic                 pop_en;
  logic [WIDTH-1:0]     pop_data;
  logic [PORT_W-1:0]    pop_port;

  // One FIFO per source port; ready is simply "not full".
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign in_ready[i] = !full[i];
      assign push[i]     = in_valid[i] && !full[i];

      slot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[i]),
        .push_data (in_data[i*WIDTH +: WIDTH]),
        .pop       (pop[i]),
        .head      (head[i]),
        .full      (full[i]),
        .empty     (empty[i])
      );
    end
  endgenerate

  // Output stage can take a new word when empty or being drained this edge.
  assign out_free = !out_valid || out_ready;

  // Decode the select into the single port that owns this cycle.
  always_comb begin
    slot = decode_sel(sel);
  end

  // Pop the owning port only if it has a word and the output stage is free;
  // emptiness is pre-edge, so a word pushed this edge cannot bypass.
  always_comb begin
    pop      = '0;
    pop_en   = 1'b0;
    pop_data = '0;
    pop_port = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (slot.valid && (slot.port == PORT_W'(i)) && !empty[i] && out_free) begin
        pop[i]   = 1'b1;
        pop_en   = 1'b1;
        pop_data = head[i];
        pop_port = PORT_W'(i);
      end
    end
  end

  // Output register: load on pop, clear on handoff, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (pop_en) begin
      out_valid <= 1'b1;
      out_data  <= pop_data;
      out_port  <= pop_port;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slot_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_slot_mux
// Brief  : Scoreboard bench for slot_mux with a queue-based reference model,
//          directed scenarios followed by randomized traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_slot_mux;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        sel;
  logic [2:0]        in_valid;
  logic [3*WIDTH-1:0] in_data;
  logic [2:0]        in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_port;
  logic              out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per port plus the output holding register.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] mq2[$];
  logic       mv;
  logic [7:0] md;
  logic [1:0] mp;
  // Scoreboard of {port, data} in the order words enter the output stage.
  logic [9:0] sb[$];

  slot_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0: return mq0.size();
      1: return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  function automatic void qpush(input int p, input logic [7:0] w);
    case (p)
      0: mq0.push_back(w);
      1: mq1.push_back(w);
      default: mq2.push_back(w);
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int p);
    case (p)
      0: return mq0.pop_front();
      1: return mq1.pop_front();
      default: return mq2.pop_front();
    endcase
  endfunction

  function automatic void model_clear();
    mq0.delete(); mq1.delete(); mq2.delete(); sb.delete();
    mv = 1'b0; md = '0; mp = '0;
  endfunction

  // Monitor: every handoff the DUT presents must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {22'd0, out_port, out_data}, 32'h3ff);
        end else begin
          chk("handoff_word", {22'd0, out_port, out_data}, {22'd0, sb.pop_front()});
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+2.
  task automatic step(input logic [2:0] v, input logic [23:0] d,
                      input logic [1:0] s, input logic r);
    logic [2:0] rdy;
    int         slot;
    bit         do_pop;
    logic [7:0] w;
    in_valid = v; in_data = d; sel = s; out_ready = r;
    #1;
    for (int i = 0; i < 3; i++) rdy[i] = (qsize(i) < DEPTH);
    chk("in_ready", {29'd0, in_ready}, {29'd0, rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    if (mv) begin
      chk("out_data", {24'd0, out_data}, {24'd0, md});
      chk("out_port", {30'd0, out_port}, {30'd0, mp});
    end
    slot = (s == 2'b10) ? 0 : (s == 2'b01) ? 1 : (s == 2'b00) ? 2 : -1;
    do_pop = (slot >= 0) && (qsize(slot) > 0) && (!mv || r);
    w = '0;
    if (do_pop) w = qpop(slot);
    for (int i = 0; i < 3; i++) if (v[i] && rdy[i]) qpush(i, d[i*8 +: 8]);
    if (do_pop) begin
      mv = 1'b1; md = w; mp = 2'(slot);
      sb.push_back({2'(slot), w});
    end else if (mv && r) begin
      mv = 1'b0;
    end
    @(posedge clk); #2;
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) begin
      step(3'b000, 24'd0, 2'b10, 1'b1);
      step(3'b000, 24'd0, 2'b01, 1'b1);
      step(3'b000, 24'd0, 2'b00, 1'b1);
    end
    step(3'b000, 24'd0, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
  endtask

  initial begin
    // Reset held with all ports offering words: nothing may be accepted.
    rst_n = 1'b0; in_valid = 3'b111; in_data = 24'hA5C3E1;
    sel = 2'b10; out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_port", {30'd0, out_port}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    rst_n = 1'b1;
    in_valid = 3'b000;
    step(3'b000, 24'd0, 2'b10, 1'b1);
    step(3'b000, 24'd0, 2'b01, 1'b1);
    step(3'b000, 24'd0, 2'b00, 1'b1);

    // Rotation: one word per port, then the cycler order 10, 01, 00.
    step(3'b111, {8'hC0, 8'hB0, 8'hA0}, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b10, 1'b1);
    step(3'b000, 24'd0, 2'b01, 1'b1);
    step(3'b000, 24'd0, 2'b00, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);

    // Back-pressure: port 0 holds 0x11, 0x22; output stalls on 0x11.
    step(3'b001, 24'h000011, 2'b11, 1'b1);
    step(3'b001, 24'h000022, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b10, 1'b0);
    for (int k = 0; k < 4; k++) step(3'b000, 24'd0, 2'b10, 1'b0);
    step(3'b000, 24'd0, 2'b10, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);

    // Full: five pushes to port 1 with no slot; fifth is refused.
    for (int k = 0; k < 5; k++) step(3'b010, {8'h00, 8'(8'h40 + k), 8'h00}, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b01, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    drain();

    // Idle slot: all ports loaded, select 11 only drains the held word.
    step(3'b111, {8'h31, 8'h21, 8'h11}, 2'b11, 1'b0);
    step(3'b111, {8'h32, 8'h22, 8'h12}, 2'b11, 1'b0);
    step(3'b000, 24'd0, 2'b10, 1'b0);
    step(3'b000, 24'd0, 2'b11, 1'b0);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);
    drain();

    // Mid-operation reset with a held word and partly full FIFOs.
    step(3'b111, {8'h93, 8'h92, 8'h91}, 2'b11, 1'b0);
    step(3'b111, {8'h96, 8'h95, 8'h94}, 2'b10, 1'b0);
    step(3'b000, 24'd0, 2'b11, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {29'd0, in_ready}, 32'd7);
    model_clear();
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(3'b000, 24'd0, 2'b10, 1'b1);
    step(3'b000, 24'd0, 2'b01, 1'b1);
    step(3'b000, 24'd0, 2'b00, 1'b1);
    step(3'b000, 24'd0, 2'b11, 1'b1);

    // Randomized traffic with occasional back-pressure and idle slots.
    for (int k = 0; k < 600; k++) begin
      step(3'($urandom_range(0, 7)), 24'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    drain();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
